// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC phase-difference stream block.
//   - phase_state_e : PRIME (no history yet) / RUN (history valid)
//   - angle_full_turn(dw) : LSBs per full turn for a dw-bit angle field
//   - field helpers : bit positions of the magnitude and angle fields
//                     inside a 2*dw-bit {magnitude, angle} word
// No ports (package).
// ----------------------------------------------------------------------------
package cordic_pkg;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } phase_state_e;

    // The angle MSB is not part of the angle, so a full turn spans 2^(dw-1).
    function automatic int angle_full_turn(input int dw);
        return 1 << (dw - 1);
    endfunction

    function automatic int mag_lsb(input int dw);
        return dw;
    endfunction

    function automatic int mag_msb(input int dw);
        return 2 * dw - 1;
    endfunction

    // Highest angle bit that carries phase information.
    function automatic int angle_msb(input int dw);
        return dw - 2;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// ----------------------------------------------------------------------------
// axis_out_reg
// Single-entry registered AXI-Stream output stage. Accepts a new word whenever
// the register is empty or being drained in the same cycle, so back-to-back
// transfers proceed without bubbles.
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_valid/s_ready       upstream handshake (s_ready is combinational)
//   s_data[W-1:0], s_last upstream payload
//   m_valid/m_ready       downstream handshake (m_valid registered)
//   m_data[W-1:0], m_last registered payload, held while stalled
// ----------------------------------------------------------------------------
module axis_out_reg #(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last
);

    logic         valid_reg;
    logic [W-1:0] data_reg;
    logic         last_reg;
    logic         load;

    assign s_ready = !valid_reg || m_ready;
    assign load    = s_valid && s_ready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= s_data;
            last_reg  <= s_last;
        end else if (m_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign m_valid = valid_reg;
    assign m_data  = data_reg;
    assign m_last  = last_reg;

endmodule

// File: rtl/cordic_phase_diff_axi_stream.sv
// ----------------------------------------------------------------------------
// cordic_phase_diff_axi_stream
// Converts a stream of {magnitude, angle} CORDIC results into
// {magnitude, signed phase delta} where delta is the wrapped difference
// between the current angle and the previous one. The first sample of a
// packet (after reset or after tlast) has no reference and yields delta 0.
// Optional squelch: build with CORDIC_PHASE_DIFF_SQUELCH_EN defined to zero
// the delta of low-magnitude samples and restart phase tracking after them.
// Ports:
//   aclk, areset                    clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast input stream  {mag, angle}
//   m_axis_tdata/tvalid/tready/tlast output stream {mag, delta}, 1-cycle latency
//   squelch_active                  current output sample was squelched
// ----------------------------------------------------------------------------
module cordic_phase_diff_axi_stream
    import cordic_pkg::*;
#(
    parameter int                   CORDIC_DW      = 16,
    parameter logic [CORDIC_DW-1:0] SQUELCH_THRESH = CORDIC_DW'(64)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [2*CORDIC_DW-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [2*CORDIC_DW-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   squelch_active
);

    localparam int AW     = $clog2(angle_full_turn(CORDIC_DW));
    localparam int MAG_HI = mag_msb(CORDIC_DW);
    localparam int MAG_LO = mag_lsb(CORDIC_DW);
    localparam int ANG_HI = angle_msb(CORDIC_DW);
    localparam int OW     = 2 * CORDIC_DW + 1;

    phase_state_e           state_reg, state_next;
    logic [AW-1:0]          history_reg, history_next;
    logic [CORDIC_DW-1:0]   s_mag;
    logic [AW-1:0]          s_angle;
    logic [AW-1:0]          diff;
    logic [CORDIC_DW-1:0]   delta;
    logic                   squelch_now;
    logic                   in_fire;
    logic [OW-1:0]          out_word;
    logic                   unused_angle_msb;

    assign s_mag            = s_axis_tdata[MAG_HI:MAG_LO];
    assign s_angle          = s_axis_tdata[ANG_HI:0];
    assign unused_angle_msb = s_axis_tdata[CORDIC_DW-1];
    assign in_fire          = s_axis_tvalid && s_axis_tready;

    // Modular subtraction over one turn; the top bit of the wrapped result
    // becomes the sign, so a half-turn difference lands on the negative end.
    assign diff = s_angle - history_reg;

`ifdef CORDIC_PHASE_DIFF_SQUELCH_EN
    assign squelch_now    = (s_mag < SQUELCH_THRESH);
    assign squelch_active = out_word[OW-1];
`else
    logic unused_squelch;
    assign squelch_now    = 1'b0;
    assign squelch_active = 1'b0;
    assign unused_squelch = ^{out_word[OW-1], SQUELCH_THRESH};
`endif

    always_comb begin
        state_next   = state_reg;
        history_next = history_reg;
        delta        = '0;
        if (!squelch_now && state_reg == ST_RUN) begin
            delta = {diff[AW-1], diff};
        end
        if (in_fire) begin
            // A squelched sample is not a valid phase reference.
            if (!squelch_now) begin
                history_next = s_angle;
            end
            state_next = (s_axis_tlast || squelch_now) ? ST_PRIME : ST_RUN;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg   <= ST_PRIME;
            history_reg <= '0;
        end else begin
            state_reg   <= state_next;
            history_reg <= history_next;
        end
    end

    axis_out_reg #(
        .W (OW)
    ) u_out (
        .aclk    (aclk),
        .areset  (areset),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .s_data  ({squelch_now, s_mag, delta}),
        .s_last  (s_axis_tlast),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (out_word),
        .m_last  (m_axis_tlast)
    );

    assign m_axis_tdata = out_word[2*CORDIC_DW-1:0];

endmodule

// File: doc/cordic_phase_diff_axi_stream.md
CORDIC_PHASE_DIFF_AXI_STREAM -- requirements
Module: cordic_phase_diff_axi_stream

Interface
REQ-001 Parameter CORDIC_DW, default 16: field width; legal range 8-24.
REQ-002 Parameter SQUELCH_THRESH, default 64: magnitude threshold in magnitude LSBs; width CORDIC_DW.
REQ-003 aclk  input  1: single clock; all logic on the rising edge.
REQ-004 areset  input  1: reset; synchronous, active-high.
REQ-005 s_axis_tdata  input  2*CORDIC_DW: [2*DW-1:DW] unsigned magnitude; [DW-1:0] angle.
REQ-006 s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1 each: AXI-Stream slave.
REQ-007 m_axis_tdata  output  2*CORDIC_DW: [2*DW-1:DW] magnitude, passed through; [DW-1:0] signed phase delta.
REQ-008 m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1 each: AXI-Stream master.
REQ-009 squelch_active  output  1: high while the current sample is squelched.

Function
REQ-010 Angle field: unsigned; one full turn = 2^(DW-1) LSBs; bit DW-1 ignored.
REQ-011 Input handshake: transfer on s_axis_tvalid & s_axis_tready.
REQ-012 s_axis_tready = !m_axis_tvalid | m_axis_tready; the path is combinational from registered state plus m_axis_tready.
REQ-013 Output data/valid/last are registered; latency is exactly 1 cycle from input transfer to m_axis_tvalid.
REQ-014 The output holds stable while m_axis_tvalid & !m_axis_tready.
REQ-015 m_axis_tvalid clears on an output transfer with no simultaneous input transfer.
REQ-016 Simultaneous input and output transfer: the output register loads the new sample; no bubble.
REQ-017 FSM has two states, PRIME and RUN:
  - Reset enters PRIME.
  - In PRIME, an accepted sample yields delta = 0, stores its angle as history, and goes to RUN.
  - In RUN, delta = (angle - history) mod 2^(DW-1), sign-extended from bit DW-2 to DW bits.
  - In RUN, history updates to the current angle.
REQ-018 Delta range is [-2^(DW-2), 2^(DW-2)-1]; the half-turn difference maps to -2^(DW-2).
REQ-019 An accepted sample with s_axis_tlast = 1 is processed normally, propagates to m_axis_tlast, and forces the next state to PRIME.
REQ-020 Magnitude is forwarded unmodified for every sample.

Reset
REQ-021 On areset: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, squelch_active = 0, history = 0, state = PRIME.
REQ-022 Reset asserted mid-stream discards the held output sample and history.
REQ-023 s_axis_tready is 1 in the cycle after reset deasserts.

Configuration
REQ-024 Macro CORDIC_PHASE_DIFF_SQUELCH_EN enables squelch.
REQ-025 With the macro defined, an accepted sample with magnitude < SQUELCH_THRESH:
  - outputs delta = 0 and sets squelch_active = 1 for that output sample;
  - leaves history unchanged and forces the next state to PRIME.
REQ-026 With the macro defined, tlast precedence on a squelched sample is unchanged: tlast still propagates.
REQ-027 Without the macro, squelch_active is tied 0, SQUELCH_THRESH is unused, and no comparator is synthesised.

Structure
REQ-028 A shared package cordic_pkg holds:
  - the state enum (PRIME, RUN);
  - the angle-full-turn localparam function of CORDIC_DW;
  - field-slicing helper constants.
REQ-029 The output register/handshake is one sub-module, axis_out_reg, parameterised on data width; phase arithmetic and FSM stay in the top module.

Verification
REQ-030 DW=16, angles 100, 300, always ready -> deltas 0, +200; latency 1 cycle.
REQ-031 Angles 32700 then 100 -> second delta +168; angles 100 then 32700 -> second delta -168 (0xFF58).
REQ-032 Angles 0 then 16384 -> delta -16384 (0xC000).
REQ-033 Three samples, tlast on the 2nd, angles 10, 20, 50 -> deltas 0, +10, 0; m_axis_tlast only on the 2nd.
REQ-034 m_axis_tready low for 5 cycles with s_axis_tvalid held -> output held stable, s_axis_tready low, no sample lost or duplicated.
REQ-035 With the macro defined, SQUELCH_THRESH=64, mags 100, 10, 100, 100 with angles 0, 50, 200, 260 -> deltas 0, 0, 0, +60; squelch_active 0, 1, 0, 0.
